// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared types and constants for the UART frame receiver.
// Revision : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W_DEF = 6;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : Bit-period counter with 3-sample mid-bit majority vote.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_rx_in,
    input  logic                  i_run,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_sampled_bit,
    output logic                  o_bit_done
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [PRESCALE_W-1:0] w_mid;
    logic [2:0]            r_samples;

    assign w_mid      = i_prescale >> 1;
    assign o_bit_done = (r_edge_cnt == i_prescale - PRESCALE_W'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_edge_cnt <= '0;
            r_samples  <= '0;
        end else if (!i_run) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= o_bit_done ? '0 : r_edge_cnt + PRESCALE_W'(1);
            if (r_edge_cnt == w_mid - PRESCALE_W'(1)) r_samples[0] <= i_rx_in;
            if (r_edge_cnt == w_mid)                  r_samples[1] <= i_rx_in;
            if (r_edge_cnt == w_mid + PRESCALE_W'(1)) r_samples[2] <= i_rx_in;
        end
    end

    // All three samples are settled well before edge P-1, where the vote is used.
    assign o_sampled_bit = (r_samples[0] & r_samples[1]) |
                           (r_samples[0] & r_samples[2]) |
                           (r_samples[1] & r_samples[2]);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Brief    : UART frame receiver: start/data/parity/stop FSM with pulse outputs.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t             r_state;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_bad;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic [PRESCALE_W-1:0] w_eff_prescale;
    logic                  w_run;
    logic                  w_sampled_bit;
    logic                  w_bit_done;

    always_comb begin
        w_eff_prescale = PRESCALE_W'(PRESCALE_8);
        if (Prescale == PRESCALE_W'(PRESCALE_16))
            w_eff_prescale = PRESCALE_W'(PRESCALE_16);
        else if (Prescale == PRESCALE_W'(PRESCALE_32))
            w_eff_prescale = PRESCALE_W'(PRESCALE_32);
    end

    // The start-detect cycle itself is edge 0, so the counter runs from it.
    assign w_run = (r_state != IDLE) || !RX_IN;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .i_rx_in       (RX_IN),
        .i_run         (w_run),
        .i_prescale    (r_prescale),
        .o_sampled_bit (w_sampled_bit),
        .o_bit_done    (w_bit_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_p_data     <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_prescale   <= PRESCALE_W'(PRESCALE_8);
            r_par_bad    <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!RX_IN) begin
                        r_state    <= START;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_prescale <= w_eff_prescale;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_state   <= w_sampled_bit ? IDLE : DATA;
                        r_bit_cnt <= '0;
                        r_par_bad <= 1'b0;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_shift <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))
                            r_state <= r_par_en ? PARITY : STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (w_bit_done) begin
                        r_par_bad <= (w_sampled_bit != ((^r_shift) ^ r_par_typ));
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_state <= IDLE;
                        if (w_sampled_bit && !r_par_bad) begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shift;
                        end else begin
                            r_par_err <= r_par_bad;
                            r_stp_err <= !w_sampled_bit;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Brief    : Self-checking bench for uart_rx_frame against a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_frame;

    logic       CLK      = 1'b0;
    logic       RST      = 1'b1;
    logic       RX_IN    = 1'b1;
    logic       PAR_EN   = 1'b0;
    logic       PAR_TYP  = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int dv;
        int pe;
        int se;
        int data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        act_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_frame u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (data_valid || par_err || stp_err)
            act_q.push_back('{cyc, int'(data_valid), int'(par_err), int'(stp_err), int'(P_DATA)});
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int eff_p(input logic [5:0] p);
        if (p == 6'd16) return 16;
        if (p == 6'd32) return 32;
        return 8;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        tick(n);
    endtask

    // Drives one frame bit-by-bit; after the start bit the config inputs are
    // scrambled to show they are ignored. abort_after >= 0 stops driving early.
    task automatic send_frame(input logic [7:0] data, input logic [5:0] p,
                              input bit pen, input bit ptyp, input bit bad_par,
                              input bit stop_val, input int glitch_bit,
                              input int gsel, input int abort_after);
        int         P;
        int         nbits;
        int         goff;
        int         n;
        int         start_cyc;
        logic [10:0] bits;
        ev_t        e;
        P     = eff_p(p);
        nbits = pen ? 11 : 10;
        goff  = P / 2 - 1 + gsel;
        n     = 0;
        bits  = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (pen) begin
            bits[9]  = (^data) ^ ptyp ^ bad_par;
            bits[10] = stop_val;
        end else begin
            bits[9] = stop_val;
        end
        Prescale  = p;
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        start_cyc = cyc;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < P; k++) begin
                if (abort_after >= 0 && n == abort_after) return;
                RX_IN = (b == glitch_bit && k == goff) ? ~bits[b] : bits[b];
                tick(1);
                n++;
                if (b == 0 && k == P - 1) begin
                    Prescale = 6'($urandom_range(0, 63));
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
            end
        end
        RX_IN = 1'b1;
        e.cyc = start_cyc + nbits * P;
        e.pe  = (pen && bad_par) ? 1 : 0;
        e.se  = stop_val ? 0 : 1;
        if (e.pe == 0 && e.se == 0) begin
            e.dv      = 1;
            last_good = data;
        end else begin
            e.dv = 0;
        end
        e.data = int'(last_good);
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        chk($sformatf("%s count", tag), act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("%s[%0d] cycle", tag, i), act_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s[%0d] data_valid", tag, i), act_q[i].dv, exp_q[i].dv);
            chk($sformatf("%s[%0d] par_err", tag, i), act_q[i].pe, exp_q[i].pe);
            chk($sformatf("%s[%0d] stp_err", tag, i), act_q[i].se, exp_q[i].se);
            chk($sformatf("%s[%0d] P_DATA", tag, i), act_q[i].data, exp_q[i].data);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [5:0] plist [6];
        plist = '{6'd8, 6'd16, 6'd32, 6'd0, 6'd12, 6'd63};

        tick(3);
        chk("reset P_DATA", P_DATA, 0);
        chk("reset data_valid", data_valid, 0);
        chk("reset par_err", par_err, 0);
        chk("reset stp_err", stp_err, 0);
        RST = 1'b0;
        idle(4);

        send_frame(8'hAA, 6'd16, 0, 0, 0, 1, -1, 0, -1);
        idle(3);
        compare_events("t1_aa_p16");

        send_frame(8'hCC, 6'd8, 1, 0, 0, 1, -1, 0, -1);
        idle(2);
        send_frame(8'hCC, 6'd8, 1, 0, 1, 1, -1, 0, -1);
        idle(3);
        compare_events("t2_parity");

        send_frame(8'hDD, 6'd8, 0, 0, 0, 0, -1, 0, -1);
        idle(3);
        compare_events("t3_stop");

        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        tick(3);
        idle(8);
        compare_events("t4_glitch_start");
        send_frame(8'hBB, 6'd8, 0, 0, 0, 1, -1, 0, -1);
        idle(3);
        compare_events("t4_after_glitch");

        send_frame(8'hBB, 6'd32, 0, 0, 0, 1, -1, 0, -1);
        send_frame(8'hDD, 6'd32, 0, 0, 0, 1, -1, 0, -1);
        send_frame(8'h3C, 6'd32, 0, 0, 0, 1, -1, 0, 100);
        RST   = 1'b1;
        RX_IN = 1'b1;
        #1;
        chk("t5 rst P_DATA", P_DATA, 0);
        chk("t5 rst data_valid", data_valid, 0);
        chk("t5 rst par_err", par_err, 0);
        chk("t5 rst stp_err", stp_err, 0);
        tick(3);
        RST = 1'b0;
        idle(400);
        compare_events("t5_b2b_reset");
        last_good = 8'h00;
        send_frame(8'h81, 6'd32, 1, 1, 0, 1, -1, 0, -1);
        idle(3);
        compare_events("t5_recover");

        send_frame(8'h55, 6'd16, 0, 0, 0, 1, 4, 1, -1);
        idle(3);
        compare_events("t6_noise");

        for (int i = 0; i < 40; i++) begin
            logic [5:0] p;
            bit         pen;
            int         gb;
            p   = plist[$urandom_range(0, 5)];
            pen = 1'($urandom);
            gb  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, pen ? 10 : 9) : -1;
            send_frame(8'($urandom), p, pen, 1'($urandom),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
                       gb, $urandom_range(0, 2), -1);
            idle($urandom_range(0, 2));
        end
        idle(3);
        compare_events("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial-to-parallel UART receiver running in the RX clock domain. This clock is oversampled at baud × Prescale.
- Detects a start bit and oversamples each bit with a 3-sample majority vote.
- Checks optional parity and the stop bit.
- Emits one 8-bit byte with a single-cycle valid pulse.
- Feeds the RX data synchronizer whose output drives the system controller's RX_P_DATA/RX_D_VLD command stream (AA/BB/CC/DD frames).

Parameters:
- DATA_WIDTH, 8, payload bits per frame (LSB first).
- PRESCALE_W, 6, width of the Prescale input.

Ports:
- CLK  input  1  oversampled RX clock (baud × Prescale)
- RST  input  1  asynchronous, active-high reset
- RX_IN  input  1  serial line, idle high; already synchronous to CLK (synchronizer is outside this block)
- PAR_EN  input  1  1 = a parity bit follows the data
- PAR_TYP  input  1  0 = even, 1 = odd
- Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- P_DATA  output  DATA_WIDTH  last good byte
- data_valid  output  1  one-cycle pulse, good frame
- par_err  output  1  one-cycle pulse, parity mismatch
- stp_err  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset (async, RST=1):
  - State = IDLE; counters = 0.
  - P_DATA=0, data_valid=0, par_err=0, stp_err=0.
  - Reset mid-frame discards the partial frame and produces no pulse.
- Config latch: PAR_EN, PAR_TYP and Prescale are captured on the start-detect cycle and held for the whole frame. Changes mid-frame have no effect.
- Illegal Prescale (anything other than 16 or 32): treated as 8.
- Start detect: in IDLE, the first cycle with RX_IN=0 is edge 0 of the start bit.
- Bit timing:
  - Each bit spans exactly Prescale cycles; edge_cnt runs 0..Prescale-1.
  - Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1.
  - Bit value = majority of the 3 samples.
  - The state transition occurs on edge_cnt = P-1.
- FSM states: IDLE -> START -> DATA -> [PARITY if PAR_EN] -> STOP -> IDLE.
  - START: a sampled value of 1 is a glitch. Return to IDLE at the end of the bit; no outputs.
  - DATA: DATA_WIDTH bits, LSB first, into an internal shift register; bit_cnt runs 0..DATA_WIDTH-1.
  - PARITY: expected parity = XOR of the data (even), or its inverse (odd). A mismatch sets an internal error flag.
  - STOP: a sampled 0 sets the stop-error flag.
- Outputs, registered, asserted in the cycle after the last STOP cycle (which is also the first IDLE cycle):
  - No errors: data_valid=1 and P_DATA is loaded.
  - Otherwise: par_err and/or stp_err pulse; data_valid=0; P_DATA keeps its old value.
  - Both errors may pulse in the same cycle.
  - All pulses last exactly 1 cycle.
- Latency:
  - Start-detect cycle = cycle 0; data_valid at cycle 10·P (no parity) or 11·P (with parity).
  - Example: P=8 without parity gives cycle 80.
- Back-to-back frames: a start bit beginning immediately after STOP is detected in that first IDLE cycle. No idle gap is required and no frame is lost.
- Noise: a single corrupted sample inside the 3-sample window does not change the bit value.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants PRESCALE_8/16/32;
  - DATA_WIDTH default.
- Sub-module uart_rx_sampler:
  - contains the edge_cnt counter, the 3-sample capture and the majority vote;
  - outputs sampled_bit and bit_done (edge_cnt = P-1).
- The top level holds the FSM, bit_cnt, shift register, parity/stop check and output registers.

Test Plan:
1. P=16, PAR_EN=0, frame 0xAA -> data_valid pulse at cycle 160, P_DATA=0xAA, no error pulses.
2. P=8, PAR_EN=1, PAR_TYP=0, byte 0xCC with parity bit 0 -> data_valid at cycle 88, P_DATA=0xCC. Repeat with parity bit 1 -> par_err pulse at cycle 88, no data_valid, P_DATA stays 0xCC.
3. P=8, byte 0xDD with stop bit 0 -> stp_err pulse at cycle 80, no data_valid, P_DATA unchanged.
4. P=8, RX_IN low for 3 cycles then high -> start samples 1,1,1, FSM returns to IDLE at cycle 8, no pulses. Then a clean frame 0xBB is received correctly.
5. P=32, frames 0xBB then 0xDD back-to-back with no gap -> data_valid at cycles 320 and 640, P_DATA=0xBB then 0xDD. Then assert RST at cycle 100 of a third frame -> all outputs 0 and no pulse.
6. P=16, a one-cycle inverted glitch on the middle sample of data bit 3 of 0x55 -> P_DATA=0x55, data_valid at cycle 160; Prescale changed mid-frame has no effect.
